// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
//
// Collects a variable-length instruction from a byte stream and presents it
// as one decoded word. Each instruction is an opcode byte followed by 0, 1 or
// 2 operand bytes:
//   opcode[7:6] = operand count N (3 is illegal)
//   opcode[5:4] = ignored
//   opcode[3:0] = op_code
// Once the last byte has been taken, op_valid pulses for one cycle. During
// that cycle the decoder stalls the stream (ready low). An illegal opcode is
// dropped and op_error pulses for one cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        byte-valid strobe; a byte is taken when start && ready
//   data_in      opcode or operand byte (DATA_W bits, opcode uses [7:0])
//   ready        decoder can accept a byte this cycle (from state register)
//   op_valid     one-cycle pulse; op_code/operand_a/operand_b are valid
//   op_code      operation code = opcode[3:0]
//   operand_a    first operand, 0 if the instruction supplies none
//   operand_b    second operand, 0 if the instruction supplies fewer than 2
//   op_error     one-cycle pulse; illegal opcode (N=3) was taken
//   instr_count  number of op_valid pulses since reset, wraps at 256
// -----------------------------------------------------------------------------
module instr_decoder #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              op_valid,
  output logic [3:0]        op_code,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic              op_error,
  output logic [7:0]        instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPND_A = 2'd1,
    S_OPND_B = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_two_ops;     // current instruction carries a second operand
  logic              r_op_valid;
  logic              r_op_error;
  logic [3:0]        r_op_code;
  logic [DATA_W-1:0] r_operand_a;
  logic [DATA_W-1:0] r_operand_b;
  logic [7:0]        r_instr_count;

  logic              w_accept;
  logic [1:0]        w_num_ops;

  // ready is the only output decoded straight from the state register, so
  // the fetch stage sees the stall in the same cycle as op_valid.
  assign ready     = (r_state != S_EMIT);
  assign w_accept  = start && ready;
  assign w_num_ops = data_in[7:6];

  assign op_valid    = r_op_valid;
  assign op_error    = r_op_error;
  assign op_code     = r_op_code;
  assign operand_a   = r_operand_a;
  assign operand_b   = r_operand_b;
  assign instr_count = r_instr_count;

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below reads the pre-edge values of the registers, independent of the
  // order the statements are written in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_two_ops     <= 1'b0;
      r_op_valid    <= 1'b0;
      r_op_error    <= 1'b0;
      r_op_code     <= '0;
      r_operand_a   <= '0;
      r_operand_b   <= '0;
      r_instr_count <= '0;
    end else begin
      // Both pulses default low; they are only raised for the single edge
      // that produces them.
      r_op_valid <= 1'b0;
      r_op_error <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_num_ops == 2'd3) begin
              // Illegal opcode: flag it, keep the previous decode intact.
              r_op_error <= 1'b1;
            end else begin
              r_op_code   <= data_in[3:0];
              r_operand_a <= '0;
              r_operand_b <= '0;
              r_two_ops   <= (w_num_ops == 2'd2);
              if (w_num_ops == 2'd0) begin
                r_state       <= S_EMIT;
                r_op_valid    <= 1'b1;
                r_instr_count <= r_instr_count + 8'd1;
              end else begin
                r_state <= S_OPND_A;
              end
            end
          end
        end

        S_OPND_A: begin
          if (w_accept) begin
            r_operand_a <= data_in;
            if (r_two_ops) begin
              r_state <= S_OPND_B;
            end else begin
              r_state       <= S_EMIT;
              r_op_valid    <= 1'b1;
              r_instr_count <= r_instr_count + 8'd1;
            end
          end
        end

        S_OPND_B: begin
          if (w_accept) begin
            r_operand_b   <= data_in;
            r_state       <= S_EMIT;
            r_op_valid    <= 1'b1;
            r_instr_count <= r_instr_count + 8'd1;
          end
        end

        S_EMIT: begin
          // One stall cycle while the decoded word is presented; any start
          // seen here is ignored because ready is low.
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter: DATA_W, default 8, width of the byte stream and of the operand outputs.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  byte-valid strobe from the fetch stage.
REQ-005 SHALL have port: data_in  input  DATA_W  opcode or operand byte.
REQ-006 SHALL have port: ready  output  1  decoder can accept a byte this cycle.
REQ-007 SHALL have port: op_valid  output  1  one-cycle pulse; decoded instruction outputs are valid.
REQ-008 SHALL have port: op_code  output  4  operation code = opcode byte [3:0].
REQ-009 SHALL have port: operand_a  output  DATA_W  first operand, 0 if not supplied.
REQ-010 SHALL have port: operand_b  output  DATA_W  second operand, 0 if not supplied.
REQ-011 SHALL have port: op_error  output  1  one-cycle pulse; illegal opcode seen.
REQ-012 SHALL have port: instr_count  output  8  count of op_valid pulses since reset.

Function
REQ-013 SHALL treat a byte as accepted only at a rising edge where start=1 and ready=1; start with ready=0 is ignored, no error.
REQ-014 SHALL decode the opcode byte as: [7:6] operand count N (0, 1, 2; 3 illegal), [5:4] ignored, [3:0] op_code.
REQ-015 SHALL implement states IDLE, OPND_A, OPND_B, EMIT, with ready=1 in IDLE/OPND_A/OPND_B and ready=0 in EMIT.
REQ-016 SHALL, in IDLE on an accepted opcode, register op_code and go to: EMIT if N=0, OPND_A if N=1 or 2, stay IDLE if N=3.
REQ-017 SHALL, in OPND_A on an accepted byte, load operand_a and go to OPND_B if N=2, else to EMIT.
REQ-018 SHALL, in OPND_B on an accepted byte, load operand_b and go to EMIT.
REQ-019 SHALL clear operand_a and operand_b to 0 when the opcode is accepted, so operands that are not supplied read 0.
REQ-020 SHALL drive op_valid=1 for exactly the one cycle spent in EMIT, then return to IDLE.
REQ-021 SHALL give latency as: last byte accepted at edge K, op_valid high in cycle K..K+1, ready high again from edge K+1.
REQ-022 SHALL hold op_code, operand_a and operand_b stable from EMIT until the next accepted opcode.
REQ-023 SHALL, on N=3, pulse op_error for one cycle after the accepting edge, leave op_code/operands unchanged, keep ready=1, and not assert op_valid.
REQ-024 SHALL increment instr_count at entry to EMIT, wrapping 255 -> 0.
REQ-025 SHALL use registered outputs, except ready, which decodes from the state register.

Reset
REQ-026 SHALL, at any edge with reset=0, force state=IDLE, op_code=0, operand_a=0, operand_b=0, op_valid=0, op_error=0 and instr_count=0; ready reads 1 after that edge.
REQ-027 SHALL discard any partially collected instruction on reset mid-operation, with no op_valid or op_error emitted.

Verification
REQ-028 SHALL cover: reset, then byte 0x05 -> op_valid pulse next cycle, op_code=5, a=0x00, b=0x00, instr_count=1.
REQ-029 SHALL cover: 0x43, 0xAA -> op_code=3, a=0xAA, b=0x00; ready low only during the op_valid cycle.
REQ-030 SHALL cover: back-to-back 0x8C, 0x12, 0x34 -> op_code=0xC, a=0x12, b=0x34, op_valid one cycle after 0x34 is accepted.
REQ-031 SHALL cover: 0xC1 -> op_error single pulse, no op_valid, ready stays 1, instr_count unchanged.
REQ-032 SHALL cover: 0x82, 0x11, then reset=0 for one cycle -> no op_valid; following 0x40, 0x7F decodes op_code=0, a=0x7F, instr_count=1.
REQ-033 SHALL cover: start held high through EMIT -> byte ignored; 256 N=0 instructions -> instr_count wraps to 0.
